// File: rtl/mem_dados_param_pkg.sv
// Shared definitions for the parametrised data memory.
//   - access-size encodings carried on the size bus
//   - lane_mask: which byte lanes a store touches
//   - misaligned: alignment rule per access size
package mem_dados_param_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_INV  = 2'b11;

  // Little-endian lane enables for an access of the given size at byte offset lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // The invalid size encoding is treated as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = |lane;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_dados_param_if.sv
// Bus between the processor datapath and the data memory.
//   master: request side (mem_read/mem_write/size/sign_ext/addr/wdata, halt/pc_atual)
//   slave : memory side  (rdata/rvalid/err_*, pc_salvo/halted, access counters)
interface mem_dados_param_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              err_misalign;
  logic              err_range;
  logic              err_conflict;
  logic              halt;
  logic [31:0]       pc_atual;
  logic [31:0]       pc_salvo;
  logic              halted;
  logic [CNT_W-1:0]  n_leituras;
  logic [CNT_W-1:0]  n_escritas;

  modport master (
    output mem_read, mem_write, size, sign_ext, addr, wdata, halt, pc_atual,
    input  rdata, rvalid, err_misalign, err_range, err_conflict,
           pc_salvo, halted, n_leituras, n_escritas
  );

  modport slave (
    input  mem_read, mem_write, size, sign_ext, addr, wdata, halt, pc_atual,
    output rdata, rvalid, err_misalign, err_range, err_conflict,
           pc_salvo, halted, n_leituras, n_escritas
  );
endinterface

// File: rtl/mem_dados_param_banco_byte.sv
// One byte lane of the data memory: DEPTH bytes, synchronous write,
// registered read. The read register only updates when re is high, so the
// last loaded byte is held between loads. Contents are never reset.
//   clk   : clock
//   we    : write enable for this lane
//   re    : read enable (captures mem_q[addr] on the edge)
//   addr  : word index
//   wdata : byte to write
//   rdata : registered read byte
module mem_banco_byte #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_q;
  logic [7:0] rd_d;

  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rd_q <= rd_d;
  end

  assign rdata = rd_q;

endmodule

// File: rtl/mem_dados_param.sv
// Parametrised data memory: byte/half/word loads and stores with sign/zero
// extension, one-cycle registered read with rvalid, error pulses for
// misaligned, out-of-range and read/write-conflict requests, store blocking
// after program end and a sticky capture of the halting PC.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset (array contents are kept)
//   bus   : slave side of mem_dados_param_if (requests in, load data,
//           error pulses, halt status and access counters out)
module mem_dados_param
  import mem_dados_param_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_dados_param_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              misalign;
  logic              range_err;
  logic              st_act;
  logic              ld_act;
  logic              wr_ok;
  logic              rd_ok;
  logic [3:0]        we_lane;
  logic [31:0]       wdata_rep;
  logic [7:0]        rd_byte [4];
  logic [31:0]       rd_word;

  logic              rvalid_q,   rvalid_d;
  logic              err_mis_q,  err_mis_d;
  logic              err_rng_q,  err_rng_d;
  logic              err_cfl_q,  err_cfl_d;
  logic              rzero_q,    rzero_d;
  logic [1:0]        ld_size_q,  ld_size_d;
  logic [1:0]        ld_lane_q,  ld_lane_d;
  logic              ld_sign_q,  ld_sign_d;
  logic              halted_q,   halted_d;
  logic [31:0]       pc_salvo_q, pc_salvo_d;
  logic [CNT_W-1:0]  n_rd_q,     n_rd_d;
  logic [CNT_W-1:0]  n_wr_q,     n_wr_d;

  // Picks the addressed byte/half out of the read word and extends it.
  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] ln, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ln +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: extend_load = {{24{sx & b[7]}}, b};
      SZ_HALF: extend_load = {{16{sx & h[15]}}, h};
      default: extend_load = w;
    endcase
  endfunction

  assign idx  = bus.addr[IDX_W+1:2];
  assign lane = bus.addr[1:0];

  always_comb begin
    misalign  = misaligned(bus.size, lane);
    range_err = bus.addr[ADDR_W-1:2] >= DEPTH_IDX;
    // Store wins a conflict; once halted, stores vanish without any error.
    st_act    = bus.mem_write & ~halted_q;
    ld_act    = bus.mem_read & ~bus.mem_write;
    wr_ok     = st_act & ~misalign & ~range_err;
    rd_ok     = ld_act & ~misalign & ~range_err;
    we_lane   = wr_ok ? lane_mask(bus.size, lane) : 4'b0000;

    // Replicate store data so every lane sees its little-endian byte.
    case (bus.size)
      SZ_BYTE: wdata_rep = {4{bus.wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{bus.wdata[15:0]}};
      default: wdata_rep = bus.wdata;
    endcase

    rvalid_d   = rd_ok;
    err_mis_d  = (st_act | ld_act) & misalign;
    err_rng_d  = (st_act | ld_act) & range_err;
    err_cfl_d  = bus.mem_read & bus.mem_write;

    // rdata is forced to zero after a failed load and held otherwise.
    rzero_d    = ld_act ? (misalign | range_err) : rzero_q;
    ld_size_d  = rd_ok ? bus.size     : ld_size_q;
    ld_lane_d  = rd_ok ? lane         : ld_lane_q;
    ld_sign_d  = rd_ok ? bus.sign_ext : ld_sign_q;

    halted_d   = halted_q;
    pc_salvo_d = pc_salvo_q;
    if (bus.halt && !halted_q) begin
      halted_d   = 1'b1;
      pc_salvo_d = bus.pc_atual;
    end

    n_rd_d = n_rd_q;
    if (rd_ok && (n_rd_q != '1)) n_rd_d = n_rd_q + CNT_W'(1);
    n_wr_d = n_wr_q;
    if (wr_ok && (n_wr_q != '1)) n_wr_d = n_wr_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 1'b0;
      err_mis_q  <= 1'b0;
      err_rng_q  <= 1'b0;
      err_cfl_q  <= 1'b0;
      rzero_q    <= 1'b1;
      ld_size_q  <= SZ_WORD;
      ld_lane_q  <= 2'b00;
      ld_sign_q  <= 1'b0;
      halted_q   <= 1'b0;
      pc_salvo_q <= '0;
      n_rd_q     <= '0;
      n_wr_q     <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      err_mis_q  <= err_mis_d;
      err_rng_q  <= err_rng_d;
      err_cfl_q  <= err_cfl_d;
      rzero_q    <= rzero_d;
      ld_size_q  <= ld_size_d;
      ld_lane_q  <= ld_lane_d;
      ld_sign_q  <= ld_sign_d;
      halted_q   <= halted_d;
      pc_salvo_q <= pc_salvo_d;
      n_rd_q     <= n_rd_d;
      n_wr_q     <= n_wr_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mem_banco_byte #(.DEPTH(DEPTH)) u_banco (
      .clk   (clk),
      .we    (we_lane[g]),
      .re    (rd_ok),
      .addr  (idx),
      .wdata (wdata_rep[8*g +: 8]),
      .rdata (rd_byte[g])
    );
  end

  assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

  assign bus.rdata        = rzero_q ? 32'h0 : extend_load(rd_word, ld_size_q, ld_lane_q, ld_sign_q);
  assign bus.rvalid       = rvalid_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_range    = err_rng_q;
  assign bus.err_conflict = err_cfl_q;
  assign bus.pc_salvo     = pc_salvo_q;
  assign bus.halted       = halted_q;
  assign bus.n_leituras   = n_rd_q;
  assign bus.n_escritas   = n_wr_q;

endmodule

// File: tb/tb_mem_dados_param.sv
// Self-checking bench for mem_dados_param. Each request pushes its expected
// response {rvalid, rdata, err_misalign, err_range, err_conflict} to a queue;
// the observed response one edge later goes to a second queue and each test
// task pops and compares both. Counters are 4 bits wide here so saturation
// is reachable quickly.
module tb_mem_dados_param;
  import mem_dados_param_pkg::*;

  localparam int DEPTH = 64;
  localparam int CNT_W = 4;

  typedef logic [35:0] resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  resp_t exp_q[$];
  resp_t obs_q[$];
  string nm_q[$];

  mem_dados_param_if #(.ADDR_W(32), .CNT_W(CNT_W)) bus ();

  mem_dados_param #(.DEPTH(DEPTH), .ADDR_W(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drives one request for one cycle (called #1 after a rising edge),
  // records the expected and observed responses.
  task automatic drive(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic erv, input logic [31:0] erd,
                       input logic eem, input logic eer, input logic eec);
    exp_q.push_back({erv, erd, eem, eer, eec});
    nm_q.push_back(nm);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.size      = sz;
    bus.sign_ext  = sx;
    bus.addr      = a;
    bus.wdata     = wd;
    @(posedge clk);
    #1;
    obs_q.push_back({bus.rvalid, bus.rdata, bus.err_misalign, bus.err_range, bus.err_conflict});
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.rdata, bus.rvalid, bus.err_misalign, bus.err_range, bus.err_conflict} !== 36'h0) begin
      bad++;
      $display("FAIL reset_outputs got rdata=%h rvalid=%b err=%b%b%b want all zero", bus.rdata,
               bus.rvalid, bus.err_misalign, bus.err_range, bus.err_conflict);
    end
    total++;
    if ({bus.pc_salvo, bus.halted, bus.n_leituras, bus.n_escritas} !== '0) begin
      bad++;
      $display("FAIL reset_status got pc_salvo=%h halted=%b n_r=%0d n_w=%0d want all zero",
               bus.pc_salvo, bus.halted, bus.n_leituras, bus.n_escritas);
    end
  endtask

  task automatic test_word();
    resp_t e, o; string n;
    drive("word_store", 0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 0, 0);
    drive("word_load",  1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
    total++;
    if (bus.n_escritas !== 4'd1 || bus.n_leituras !== 4'd1) begin
      bad++;
      $display("FAIL word_counters got n_w=%0d n_r=%0d want 1 1", bus.n_escritas, bus.n_leituras);
    end
  endtask

  task automatic test_byte();
    resp_t e, o; string n;
    drive("byte_store",  0, 1, SZ_BYTE, 0, 32'h11, 32'h80, 0, 32'hDEADBEEF, 0, 0, 0);
    drive("byte_signed", 1, 0, SZ_BYTE, 1, 32'h11, 32'h0, 1, 32'hFFFFFF80, 0, 0, 0);
    drive("byte_zero",   1, 0, SZ_BYTE, 0, 32'h11, 32'h0, 1, 32'h00000080, 0, 0, 0);
    drive("word_merged", 1, 0, SZ_WORD, 1, 32'h10, 32'h0, 1, 32'hDEAD80EF, 0, 0, 0);
    drive("half_hi_sx",  1, 0, SZ_HALF, 1, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 0, 0, 0);
    drive("half_lo_zx",  1, 0, SZ_HALF, 0, 32'h10, 32'h0, 1, 32'h000080EF, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
    total++;
    if (bus.n_escritas !== 4'd2 || bus.n_leituras !== 4'd6) begin
      bad++;
      $display("FAIL byte_counters got n_w=%0d n_r=%0d want 2 6", bus.n_escritas, bus.n_leituras);
    end
  endtask

  task automatic test_errors();
    resp_t e, o; string n;
    drive("half_misalign", 1, 0, SZ_HALF, 0, 32'h13, 32'h0, 0, 32'h0, 1, 0, 0);
    drive("word_range",    1, 0, SZ_WORD, 0, DEPTH*4, 32'h0, 0, 32'h0, 0, 1, 0);
    drive("size_invalid",  1, 0, SZ_INV,  0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0);
    drive("both_errors",   1, 0, SZ_HALF, 0, 32'h101, 32'h0, 0, 32'h0, 1, 1, 0);
    drive("store_misal",   0, 1, SZ_WORD, 0, 32'h12, 32'h12345678, 0, 32'h0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
    total++;
    if (bus.n_escritas !== 4'd2 || bus.n_leituras !== 4'd6) begin
      bad++;
      $display("FAIL error_counters got n_w=%0d n_r=%0d want 2 6", bus.n_escritas, bus.n_leituras);
    end
  endtask

  task automatic test_conflict();
    resp_t e, o; string n;
    drive("conflict",      1, 1, SZ_WORD, 0, 32'h20, 32'h1234, 0, 32'h0, 0, 0, 1);
    drive("conflict_rdbk", 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 1, 32'h00001234, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
    total++;
    if (bus.n_escritas !== 4'd3 || bus.n_leituras !== 4'd7) begin
      bad++;
      $display("FAIL conflict_counters got n_w=%0d n_r=%0d want 3 7", bus.n_escritas, bus.n_leituras);
    end
  endtask

  task automatic test_back_to_back();
    resp_t e, o; string n;
    drive("b2b_word_st", 0, 1, SZ_WORD, 0, 32'h30, 32'h11223344, 0, 32'h00001234, 0, 0, 0);
    drive("b2b_half_st", 0, 1, SZ_HALF, 0, 32'h32, 32'hBEEF, 0, 32'h00001234, 0, 0, 0);
    drive("b2b_word_ld", 1, 0, SZ_WORD, 0, 32'h30, 32'h0, 1, 32'hBEEF3344, 0, 0, 0);
    drive("b2b_byte3",   1, 0, SZ_BYTE, 0, 32'h33, 32'h0, 1, 32'h000000BE, 0, 0, 0);
    drive("b2b_byte0",   1, 0, SZ_BYTE, 1, 32'h30, 32'h0, 1, 32'h00000044, 0, 0, 0);
    drive("b2b_half0",   1, 0, SZ_HALF, 1, 32'h30, 32'h0, 1, 32'h00003344, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
    total++;
    if (bus.n_escritas !== 4'd5 || bus.n_leituras !== 4'd11) begin
      bad++;
      $display("FAIL b2b_counters got n_w=%0d n_r=%0d want 5 11", bus.n_escritas, bus.n_leituras);
    end
  endtask

  task automatic test_halt();
    resp_t e, o; string n;
    bus.pc_atual = 32'h40;
    bus.halt = 1'b1;
    drive("halt_edge_st", 0, 1, SZ_WORD, 0, 32'h0, 32'hCAFEF00D, 0, 32'h00003344, 0, 0, 0);
    bus.halt = 1'b0;
    total++;
    if (bus.halted !== 1'b1 || bus.pc_salvo !== 32'h40 || bus.n_escritas !== 4'd6) begin
      bad++;
      $display("FAIL halt_capture got halted=%b pc_salvo=%h n_w=%0d want 1 00000040 6",
               bus.halted, bus.pc_salvo, bus.n_escritas);
    end
    bus.pc_atual = 32'h80;
    bus.halt = 1'b1;
    drive("halted_store", 0, 1, SZ_BYTE, 0, 32'h0, 32'h55, 0, 32'h00003344, 0, 0, 0);
    bus.halt = 1'b0;
    total++;
    if (bus.halted !== 1'b1 || bus.pc_salvo !== 32'h40 || bus.n_escritas !== 4'd6) begin
      bad++;
      $display("FAIL halt_sticky got halted=%b pc_salvo=%h n_w=%0d want 1 00000040 6",
               bus.halted, bus.pc_salvo, bus.n_escritas);
    end
    drive("halted_load", 1, 0, SZ_WORD, 0, 32'h0, 32'h0, 1, 32'hCAFEF00D, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
    total++;
    if (bus.n_leituras !== 4'd12) begin
      bad++;
      $display("FAIL halt_reads got n_r=%0d want 12", bus.n_leituras);
    end
  endtask

  task automatic test_saturate();
    resp_t e, o; string n;
    for (int i = 0; i < 20; i++)
      drive("sat_load", 1, 0, SZ_WORD, 0, 32'h0, 32'h0, 1, 32'hCAFEF00D, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
    total++;
    if (bus.n_leituras !== 4'hF || bus.n_escritas !== 4'd6) begin
      bad++;
      $display("FAIL saturate got n_r=%0d n_w=%0d want 15 6", bus.n_leituras, bus.n_escritas);
    end
  endtask

  task automatic test_mid_reset();
    resp_t e, o; string n;
    bus.mem_read = 1'b1;
    bus.size     = SZ_WORD;
    bus.addr     = 32'h10;
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    total++;
    if (bus.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_rvalid got %b want 1", bus.rvalid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || bus.halted !== 1'b0 ||
        bus.pc_salvo !== 32'h0 || bus.n_leituras !== 4'd0 || bus.n_escritas !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset got rvalid=%b rdata=%h halted=%b pc=%h n_r=%0d n_w=%0d want all zero",
               bus.rvalid, bus.rdata, bus.halted, bus.pc_salvo, bus.n_leituras, bus.n_escritas);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive("post_rst_w10", 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1, 32'hDEAD80EF, 0, 0, 0);
    drive("post_rst_w30", 1, 0, SZ_WORD, 0, 32'h30, 32'h0, 1, 32'hBEEF3344, 0, 0, 0);
    drive("post_rst_st",  0, 1, SZ_BYTE, 0, 32'h0, 32'h55, 0, 32'hBEEF3344, 0, 0, 0);
    drive("post_rst_ld",  1, 0, SZ_WORD, 0, 32'h0, 32'h0, 1, 32'hCAFEF055, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s got rv=%b rdata=%h err=%b want rv=%b rdata=%h err=%b",
                 n, o[35], o[34:3], o[2:0], e[35], e[34:3], e[2:0]);
      end
    end
  endtask

  initial begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.size      = SZ_WORD;
    bus.sign_ext  = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.halt      = 1'b0;
    bus.pc_atual  = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_word();
    test_byte();
    test_errors();
    test_conflict();
    test_back_to_back();
    test_halt();
    test_saturate();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dados_param.md
# mem_dados_param

Parametrised data memory for the single-cycle processor: the next generation of the fixed 64-word data memory. Supports byte, halfword and word loads and stores with sign/zero extension and a registered read port with a valid strobe. Flags misaligned and out-of-range accesses, blocks stores after program end, and captures the halting PC in a sticky register. Sits between the ALU address output and the write-back mux.

## Interface
- DEPTH, 64, number of 32-bit words; power of two, ≥4
- ADDR_W, 32, byte-address width
- CNT_W, 16, width of access counters
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  load request this cycle
- mem_write  in  1  store request this cycle
- size  in  2  00 byte, 01 half, 10 word, 11 invalid
- sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
- rdata  out  32  load data, extended
- rvalid  out  1  one-cycle pulse, rdata valid
- err_misalign  out  1  one-cycle pulse, misaligned or invalid size
- err_range  out  1  one-cycle pulse, word index ≥ DEPTH
- err_conflict  out  1  one-cycle pulse, read and write in same cycle
- halt  in  1  program-end flag from control
- pc_atual  in  32  current PC
- pc_salvo  out  32  PC captured at halt
- halted  out  1  sticky halt status
- n_leituras, n_escritas  out  CNT_W  saturating completed-access counters

## Operation
- Array: four byte lanes of DEPTH entries each. Word index = addr[ADDR_W-1:2], lane = addr[1:0]. Array contents are not reset.
- Alignment: half requires addr[0]=0. Word requires addr[1:0]=00. size=11 is always misaligned.
- Range: word index ≥ DEPTH (upper address bits non-zero) is out of range.
- A request with any error is suppressed: no array write, rdata=0, counters unchanged. If both errors apply, both error pulses fire.
- Store: writes only the addressed lanes (byte: 1 lane; half: lanes {addr[1],0}/+1; word: all four). Little-endian.
- Load: selects the addressed byte or half, then extends it per sign_ext. Word ignores sign_ext.
- Conflict: mem_read and mem_write both high → store proceeds, load is dropped, err_conflict pulses, no rvalid.
- Halt: when halt=1 and halted=0, capture pc_atual into pc_salvo and set halted. halted stays set until reset; later halt pulses do not recapture.
- While halted, stores are silently ignored: no write, no error, n_escritas frozen. Loads still work (memory dump).
- Counters: increment on each successful load/store and saturate at all-ones.

## Timing
- Reset values: rdata=0, rvalid=0, all err_*=0, pc_salvo=0, halted=0, counters=0.
- Store commits at the edge where mem_write is sampled.
- Load latency is 1: a request at edge t produces rdata/rvalid/err_* valid after edge t. rdata holds its value until the next load.
- Error pulses for a store also appear one cycle after the request.
- Read-after-write: a load issued the cycle after a store to the same word returns the new data.
- A store in the same cycle halt first rises is performed (halted is not yet set). Stores are blocked from the next cycle.
- Reset mid-access: pulses clear immediately and the pending load is lost. The array keeps its contents.
- Back-to-back loads are supported every cycle.

## Structure
- Shared package/header: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the lane-mask function.
- One sub-module, mem_banco_byte: single byte lane with synchronous write enable and registered read, instantiated four times.
- Alignment/extension logic stays in the top module.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → rvalid next cycle, rdata=0xDEADBEEF, n_escritas=1, n_leituras=1.
- Byte store 0x80 @0x11 over that word, then signed byte load @0x11 → 0xFFFFFF80; unsigned → 0x00000080; word @0x10 → 0xDEAD80EF.
- Half load @0x13 → err_misalign pulse, rdata=0, no counter change. Word load @(DEPTH*4) → err_range pulse.
- mem_read=mem_write=1 @0x20 with wdata=0x1234 → err_conflict, no rvalid, later load @0x20 = 0x00001234.
- pc_atual=0x40, halt=1 → pc_salvo=0x40, halted=1. halt again with pc_atual=0x80 → pc_salvo stays 0x40. Store 0x55 @0x0 is ignored; load @0x0 returns the old value.
- rst_n low mid-load → rvalid=0 immediately, halted=0, counters=0, previously stored word still readable after release.
